// File: rtl/vga_pkg.sv
// Shared constants for the VGA timing generator: default 800x600@60 geometry
// and the widths of the counter, colour and frame-count buses.
package vga_pkg;

    localparam int CNT_W   = 11;
    localparam int RGB_W   = 12;
    localparam int FRAME_W = 16;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BP     = 88;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 23;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

endpackage

// File: rtl/vga_if.sv
// Pixel-position and sync bundle passed from the timing generator to the
// draw stages.
interface vga_if;
    import vga_pkg::*;

    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             hblnk;
    logic             vsync;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;

    modport out (output hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
    modport in  (input  hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);

endinterface

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters with registered sync and blanking flags,
// a start-of-frame pulse and a running frame counter.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    vga_if.out                 out,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic             h_wrap;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        h_wrap = (h_cnt == H_LAST);
        h_next = h_wrap ? '0 : h_cnt + CNT_W'(1);
        v_next = v_cnt;
        if (h_wrap) begin
            v_next = (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every process sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
        end else if (en) begin
            h_cnt <= h_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_cnt <= '0;
        end else if (en) begin
            v_cnt <= v_next;
        end
    end

    // Flags are computed from the next counter values so they land on the
    // same edge as the counts they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            out.hsync   <= 1'b0;
            out.hblnk   <= 1'b0;
            out.vsync   <= 1'b0;
            out.vblnk   <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_start <= 1'b0;
            if (en) begin
                out.hblnk <= (h_next >= H_ACT);
                out.hsync <= (h_next >= H_SYNC_BEG) && (h_next < H_SYNC_END);
                out.vblnk <= (v_next >= V_ACT);
                out.vsync <= (v_next >= V_SYNC_BEG) && (v_next < V_SYNC_END);
                if (h_next == '0 && v_next == '0) begin
                    frame_start <= 1'b1;
                    frame_cnt   <= frame_cnt + FRAME_W'(1);
                end
            end
        end
    end

    assign out.hcount = h_cnt;
    assign out.vcount = v_cnt;
    assign out.rgb    = '0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: a default-geometry instance for line-level behaviour and
// a small-geometry instance for whole-frame behaviour, both against a raster model.
module tb_vga_timing_gen;

    // Small geometry: 24 pixels per line, 12 lines per frame.
    localparam int S_HA = 16, S_HF = 2, S_HS = 3, S_HB = 3;
    localparam int S_VA = 6,  S_VF = 1, S_VS = 2, S_VB = 3;
    localparam int D_HA = 800, D_HF = 40, D_HS = 128, D_HB = 88;
    localparam int D_VA = 600, D_VF = 1,  D_VS = 4,   D_VB = 23;
    localparam int D_HT = D_HA + D_HF + D_HS + D_HB;
    localparam int D_N  = D_HT * (D_VA + D_VF + D_VS + D_VB);
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
    localparam int S_N  = S_HT * (S_VA + S_VF + S_VS + S_VB);

    typedef struct packed {
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hs;
        logic        hb;
        logic        vs;
        logic        vb;
        logic        fs;
        logic [15:0] fc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic        frame_start_d, frame_start_s;
    logic [15:0] frame_cnt_d, frame_cnt_s;

    vga_if if_d ();
    vga_if if_s ();

    vga_timing_gen dut_d (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .out         (if_d),
        .frame_start (frame_start_d),
        .frame_cnt   (frame_cnt_d)
    );

    vga_timing_gen #(
        .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
        .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB)
    ) dut_s (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .out         (if_s),
        .frame_start (frame_start_s),
        .frame_cnt   (frame_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    // Model state: enabled-pixel count since reset, frame-count offset, last pulse.
    int   p_d = 0, base_d = 0, p_s = 0, base_s = 0;
    logic fs_d = 1'b0, fs_s = 1'b0;

    // Raster position follows from the number of enabled pixels alone.
    function automatic exp_t model(input int p, input int base, input logic fs,
                                   input int ha, input int hf, input int hs, input int hb,
                                   input int va, input int vf, input int vs, input int vb);
        exp_t e;
        int ht = ha + hf + hs + hb;
        int vt = va + vf + vs + vb;
        int h  = p % ht;
        int v  = (p / ht) % vt;
        e.hc = 11'(h);
        e.vc = 11'(v);
        e.hb = (h >= ha);
        e.hs = (h >= ha + hf) && (h < ha + hf + hs);
        e.vb = (v >= va);
        e.vs = (v >= va + vf) && (v < va + vf + vs);
        e.fs = fs;
        e.fc = 16'(base + p / (ht * vt));
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input string nm, input exp_t e,
                              input logic [10:0] hc, input logic [10:0] vc,
                              input logic hs, input logic hb, input logic vs, input logic vb,
                              input logic fs, input logic [15:0] fc, input logic [11:0] rgb);
        check({nm, ".hcount"}, 32'(hc), 32'(e.hc));
        check({nm, ".vcount"}, 32'(vc), 32'(e.vc));
        check({nm, ".hsync"}, 32'(hs), 32'(e.hs));
        check({nm, ".hblnk"}, 32'(hb), 32'(e.hb));
        check({nm, ".vsync"}, 32'(vs), 32'(e.vs));
        check({nm, ".vblnk"}, 32'(vb), 32'(e.vb));
        check({nm, ".frame_start"}, 32'(fs), 32'(e.fs));
        check({nm, ".frame_cnt"}, 32'(fc), 32'(e.fc));
        check({nm, ".hsync_outside_hblnk"}, 32'(hs & ~hb), 32'(0));
        check({nm, ".vsync_outside_vblnk"}, 32'(vs & ~vb), 32'(0));
        check({nm, ".rgb"}, 32'(rgb), 32'(0));
    endtask

    task automatic advance(inout int p, inout int base, inout logic fs,
                           input int n, input logic e, input logic r);
        if (r) begin
            p = 0; base = 0; fs = 1'b0;
        end else if (e) begin
            p++;
            fs = (p % n == 0);
        end else begin
            fs = 1'b0;
        end
    endtask

    // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
    task automatic tick(input logic e, input logic r);
        en  = e;
        rst = r;
        @(posedge clk);
        advance(p_d, base_d, fs_d, D_N, e, r);
        advance(p_s, base_s, fs_s, S_N, e, r);
        #1;
        check_inst("dflt", model(p_d, base_d, fs_d, D_HA, D_HF, D_HS, D_HB, D_VA, D_VF, D_VS, D_VB),
                   if_d.hcount, if_d.vcount, if_d.hsync, if_d.hblnk, if_d.vsync, if_d.vblnk,
                   frame_start_d, frame_cnt_d, if_d.rgb);
        check_inst("small", model(p_s, base_s, fs_s, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB),
                   if_s.hcount, if_s.vcount, if_s.hsync, if_s.hblnk, if_s.vsync, if_s.vblnk,
                   frame_start_s, frame_cnt_s, if_s.rgb);
    endtask

    initial begin
        int pulses;
        en  = 1'b0;
        rst = 1'b1;
        #1;

        // Reset state, with en randomly toggling underneath.
        repeat (3) tick(1'($urandom_range(0, 1)), 1'b1);

        // One full default line: hblnk rises at 800, line wraps into vcount=1.
        for (int i = 1; i <= D_HT; i++) begin
            tick(1'b1, 1'b0);
            if (i == 1) check("first_step_hcount", 32'(if_d.hcount), 32'd1);
            if (i == 799) check("hblnk_before_800", 32'(if_d.hblnk), 32'd0);
            if (i == 800) check("hblnk_at_800", 32'(if_d.hblnk), 32'd1);
            if (i == 840) check("hsync_at_840", 32'(if_d.hsync), 32'd1);
            if (i == 968) check("hsync_off_968", 32'(if_d.hsync), 32'd0);
        end
        check("line_end_hcount", 32'(if_d.hcount), 32'd0);
        check("line_end_vcount", 32'(if_d.vcount), 32'd1);

        // Alternating enable: one line now takes twice as many clocks.
        for (int i = 0; i < 2 * D_HT; i++) tick(1'(i % 2 == 0), 1'b0);
        check("alt_line_hcount", 32'(if_d.hcount), 32'd0);
        check("alt_line_vcount", 32'(if_d.vcount), 32'd2);

        // Whole small frame from reset: exactly one frame_start, frame_cnt=1.
        tick(1'b1, 1'b1);
        pulses = 0;
        for (int i = 0; i < S_N; i++) begin
            tick(1'b1, 1'b0);
            pulses += int'(frame_start_s);
        end
        check("frame_pulses", 32'(pulses), 32'd1);
        check("frame_start_at_end", 32'(frame_start_s), 32'd1);
        check("frame_cnt_one", 32'(frame_cnt_s), 32'd1);
        tick(1'b0, 1'b0);
        check("frame_start_drops_en0", 32'(frame_start_s), 32'd0);

        // Reset mid-frame with en held high takes priority.
        tick(1'b1, 1'b1);
        for (int i = 0; i < 5 * S_HT + 12; i++) tick(1'b1, 1'b0);
        check("mid_hcount", 32'(if_s.hcount), 32'd12);
        check("mid_vcount", 32'(if_s.vcount), 32'd5);
        tick(1'b1, 1'b1);
        check("midrst_hcount", 32'(if_s.hcount), 32'd0);
        check("midrst_frame_start", 32'(frame_start_s), 32'd0);
        tick(1'b1, 1'b1);
        check("midrst_hold_frame_start", 32'(frame_start_s), 32'd0);

        // Randomized enable with rare resets.
        for (int i = 0; i < 3000; i++)
            tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 499) == 0));

        // Preload frame_cnt to all-ones just before a frame end and watch it wrap.
        for (int i = 0; i < 2 * S_N && (p_s % S_N) != S_N - 3; i++) tick(1'b1, 1'b0);
        check("preload_position", 32'(p_s % S_N), 32'(S_N - 3));
        force dut_s.frame_cnt = 16'hFFFF;
        #1;
        release dut_s.frame_cnt;
        base_s = 16'hFFFF - p_s / S_N;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        check("wrap_frame_start", 32'(frame_start_s), 32'd1);
        check("wrap_frame_cnt", 32'(frame_cnt_s), 32'd0);
        repeat (4) tick(1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL take parameter H_ACTIVE, default 800: visible pixels per line.
REQ-002 SHALL take parameter H_FP, default 40: horizontal front porch, in pixels.
REQ-003 SHALL take parameter H_SYNC, default 128: horizontal sync width, in pixels.
REQ-004 SHALL take parameter H_BP, default 88: horizontal back porch, in pixels.
REQ-005 SHALL take parameter V_ACTIVE, default 600: visible lines per frame.
REQ-006 SHALL take parameter V_FP, default 1: vertical front porch, in lines.
REQ-007 SHALL take parameter V_SYNC, default 4: vertical sync width, in lines.
REQ-008 SHALL take parameter V_BP, default 23: vertical back porch, in lines.
REQ-009 SHALL have port clk  in  1  pixel clock.
REQ-010 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-011 SHALL have port en  in  1  pixel advance enable; when low, all state holds.
REQ-012 SHALL have port out  vga_if.out  -  fields hcount[10:0], vcount[10:0], hsync, hblnk, vsync, vblnk, rgb[11:0].
REQ-013 SHALL have port frame_start  out  1  single-cycle pulse at the first pixel (0,0) of each frame.
REQ-014 SHALL have port frame_cnt  out  16  count of completed frames since reset.

Function
REQ-015 SHALL derive H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056) and V_TOTAL likewise (default 628).
REQ-016 SHALL, on a cycle with en=1, increment hcount; at H_TOTAL-1 hcount SHALL wrap to 0.
REQ-017 SHALL increment vcount only on a cycle where hcount wraps; at V_TOTAL-1 vcount SHALL wrap to 0 on that same cycle.
REQ-018 SHALL hold hcount, vcount, all flags and frame_cnt on a cycle with en=0; frame_start SHALL be 0 on that cycle.
REQ-019 SHALL drive hblnk=1 exactly when hcount >= H_ACTIVE.
REQ-020 SHALL drive hsync=1 (positive polarity) exactly when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, i.e. 840..967 by default.
REQ-021 SHALL drive vblnk=1 exactly when vcount >= V_ACTIVE.
REQ-022 SHALL drive vsync=1 exactly when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, i.e. 601..604 by default.
REQ-023 SHALL register all flags from next-state counter values, so that flags and counts presented on the same cycle are always mutually consistent; no output SHALL be combinational from inputs.
REQ-024 SHALL drive out.rgb constantly at 12'h000; downstream draw stages supply colour.
REQ-025 SHALL assert frame_start for one cycle when the counters transition to (0,0), and SHALL NOT assert it directly out of reset.
REQ-026 SHALL increment frame_cnt on the same edge that raises frame_start; frame_cnt SHALL wrap from 16'hFFFF to 0.

Reset
REQ-027 SHALL, while rst=1, force hcount=0, vcount=0, hsync=0, vsync=0, hblnk=0, vblnk=0, rgb=0, frame_start=0 and frame_cnt=0.
REQ-028 SHALL give rst priority over en, including a reset asserted mid-line or mid-frame.
REQ-029 SHALL, on the first en=1 cycle after reset release, advance to hcount=1, vcount=0.

Structure
REQ-030 SHALL place the default timing constants in vga_pkg (H_/V_ ACTIVE, FP, SYNC, BP and TOTAL) and use them as parameter defaults.
REQ-031 SHALL be implemented as a single module with no sub-modules; the horizontal and vertical counters are two processes inside it.

Verification
REQ-032 SHALL cover: reset, then en=1 for 1056 cycles -> hblnk rises at hcount=800, hsync is high over 840..967, hcount returns to 0 with vcount=1.
REQ-033 SHALL cover: en=1 for a full frame of 1056*628 cycles -> vsync is high on lines 601..604, vblnk is high on lines 600..627, then one frame_start pulse and frame_cnt=1.
REQ-034 SHALL cover: en toggled 1/0 alternately -> counts advance only on en=1 cycles, and line length is 2112 clk cycles.
REQ-035 SHALL cover: rst asserted at hcount=500, vcount=300 with en=1 -> all outputs read 0 on the next cycle and frame_start stays 0.
REQ-036 SHALL cover: frame_cnt preloaded by forcing to 16'hFFFF, then one frame end -> frame_cnt=0 and frame_start pulses.
REQ-037 SHALL cover: a throughout-run assertion -> hsync is never high while hblnk=0, vsync is never high while vblnk=0, and rgb is always 0.
